token_pacer: RTL and testbench

TOKEN_PACER -- requirements
Module: token_pacer

---
 rtl/token_pacer.sv | 145 ++++++++++++++
 tb/tb_token_pacer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/token_pacer.sv
// token_pacer: accumulates incoming tokens in a saturating counter and hands
// them off one at a time over a valid/ready port, keeping at least GAP idle
// cycles between consecutive handshakes.
//
// Handshake: out_valid rises only from the state register and stays high
// until out_valid & out_ready is seen on a rising edge. A token is never
// withdrawn once offered. out_ready is ignored while out_valid is low.
//
// Optional feature: define TOKEN_PACER_OVF_CLR_EN to add the overflow_clr
// input, which clears the sticky overflow flag. If a drop happens on the
// same edge, the drop wins. Without the macro, only reset clears overflow.
module token_pacer #(
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_token,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
`ifdef TOKEN_PACER_OVF_CLR_EN
  ,
  input  logic             overflow_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Gap counter reload value. When GAP is 0, WAIT is never entered.
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [3:0]       gap_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             hs;
  logic             drop;

  // Next pending count: saturating +1 per token, -1 per handshake.
  // When both occur on the same edge, the count is unchanged.
  always_comb begin
    hs    = valid_q & out_ready;
    drop  = 1'b0;
    cnt_d = cnt_q;
    if (in_token && !hs) begin
      if (cnt_q == CNT_MAX) begin
        drop = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (hs && !in_token) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Next overflow value: sticky, set by a dropped token.
  always_comb begin
`ifdef TOKEN_PACER_OVF_CLR_EN
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
`else
    ovf_d = ovf_q | drop;
`endif
  end

  // Counter and overflow registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Pacing FSM. out_valid is registered together with the state so that it
  // is high exactly while in SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gap_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            if (GAP > 0) begin
              state_q <= WAIT;
              gap_q   <= GAP_LOAD;
              valid_q <= 1'b0;
            end else if (cnt_d == '0) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (gap_q == 4'd0) begin
            if (cnt_q != '0) begin
              state_q <= SEND;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gap_q   <= 4'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign pending   = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_token_pacer.sv
// Directed testbench for token_pacer with CNT_W=4 and GAP=2, in the default
// build that has no overflow_clr port.
module tb_token_pacer;

  localparam int CNT_W = 4;
  localparam int GAP   = 2;

  logic             clk;
  logic             rst;
  logic             in_token;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  int vectors  = 0;
  int miscomps = 0;
  int cyc      = 0;
  int hs_q[$];

  token_pacer #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_token  (in_token),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  // Clock generation and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor. Inputs only change just after a rising edge, so the
  // values seen at the falling edge are the ones the next rising edge samples.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) hs_q.push_back(cyc + 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscomps++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_token  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hs_q.delete();
  endtask

  int  peak;
  int  spacing_ok;
  bit  hold_ok;

  initial begin
    rst       = 1'b0;
    in_token  = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Single token, consumer always ready; token on the first edge after reset.
    do_reset();
    out_ready = 1'b1;
    in_token  = 1'b1;
    step();
    in_token = 1'b0;
    chk("single_pend_k", 32'(pending), 32'd1);
    chk("single_valid_k", 32'(out_valid), 32'd0);
    step();
    chk("single_valid_k1", 32'(out_valid), 32'd1);
    chk("single_pend_k1", 32'(pending), 32'd1);
    step();
    chk("single_valid_k2", 32'(out_valid), 32'd0);
    chk("single_pend_k2", 32'(pending), 32'd0);
    step();
    chk("single_valid_k3", 32'(out_valid), 32'd0);
    chk("single_ovf", 32'(overflow), 32'd0);

    // Five consecutive tokens, consumer always ready.
    do_reset();
    out_ready = 1'b1;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      in_token = 1'b1;
      step();
      if (int'(pending) > peak) peak = int'(pending);
    end
    in_token = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (int'(pending) > peak) peak = int'(pending);
    end
    chk("burst_hs_count", 32'(hs_q.size()), 32'd5);
    spacing_ok = 1;
    for (int i = 1; i < hs_q.size(); i++) begin
      if (hs_q[i] - hs_q[i-1] != GAP + 1) spacing_ok = 0;
    end
    chk("burst_spacing", 32'(spacing_ok), 32'd1);
    chk("burst_peak", 32'(peak), 32'd4);
    chk("burst_final_pend", 32'(pending), 32'd0);
    chk("burst_final_valid", 32'(out_valid), 32'd0);

    // Consumer stalls for 10 cycles with one token pending.
    do_reset();
    in_token = 1'b1;
    step();
    in_token = 1'b0;
    step();
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || pending !== 4'd1) hold_ok = 1'b0;
      step();
    end
    chk("stall_hold", 32'(hold_ok), 32'd1);
    hs_q.delete();
    out_ready = 1'b1;
    step();
    chk("stall_release_pend", 32'(pending), 32'd0);
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_hs_count", 32'(hs_q.size()), 32'd1);

    // Saturation: 17 tokens with the consumer stalled, then drain.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      in_token = 1'b1;
      step();
      if (i == 15) begin
        chk("sat15_pend", 32'(pending), 32'd15);
        chk("sat15_ovf", 32'(overflow), 32'd0);
      end
      if (i == 16) begin
        chk("sat16_pend", 32'(pending), 32'd15);
        chk("sat16_ovf", 32'(overflow), 32'd1);
      end
    end
    in_token = 1'b0;
    chk("sat17_pend", 32'(pending), 32'd15);
    hs_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) step();
    chk("drain_hs_count", 32'(hs_q.size()), 32'd15);
    chk("drain_pend", 32'(pending), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);
    // Asynchronous reset mid-cycle clears the sticky flag at once.
    #3;
    rst = 1'b0;
    #1;
    chk("async_ovf_clear", 32'(overflow), 32'd0);

    // Token at max together with a handshake: not dropped.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      in_token = 1'b1;
      step();
    end
    chk("full_pend", 32'(pending), 32'd15);
    chk("full_valid", 32'(out_valid), 32'd1);
    in_token  = 1'b1;
    out_ready = 1'b1;
    step();
    in_token  = 1'b0;
    out_ready = 1'b0;
    chk("max_hs_pend", 32'(pending), 32'd15);
    chk("max_hs_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset mid-SEND with six pending tokens.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_token = 1'b1;
      step();
    end
    in_token = 1'b0;
    chk("midsend_valid", 32'(out_valid), 32'd1);
    chk("midsend_pend", 32'(pending), 32'd6);
    #3;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_pend", 32'(pending), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_reset_valid", 32'(out_valid), 32'd0);
    chk("post_reset_pend", 32'(pending), 32'd0);
    step();
    chk("post_reset_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule
